// File: rtl/ifu_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues pipelined fetches to an in-order,
// variable-latency instruction memory, buffers {pc,inst} pairs and hands them
// to decode over valid/ready. A branch flush redirects fetch and arranges for
// the responses still in flight to be thrown away as they arrive.
module ifu_prefetch_queue #(
    parameter int unsigned        XLEN     = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [XLEN-1:0]    RESET_PC = '0,
    parameter logic [XLEN-1:0]    PC_STEP  = XLEN'(4)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       o_IM_req,
    output logic [XLEN-1:0]            o_IM_addr,
    input  logic                       i_IM_valid,
    input  logic [XLEN-1:0]            i_IM_inst,
    input  logic                       i_flush,
    input  logic [XLEN-1:0]            i_branch_addr,
    output logic                       o_valid,
    output logic [XLEN-1:0]            o_pc,
    output logic [XLEN-1:0]            o_inst,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_proto_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetchPc_q,  fetchPc_d;
    logic [PW-1:0]   allocPtr_q, allocPtr_d;
    logic [PW-1:0]   fillPtr_q,  fillPtr_d;
    logic [PW-1:0]   rdPtr_q,    rdPtr_d;
    logic [CW-1:0]   alloc_q,    alloc_d;
    logic [CW-1:0]   fillCnt_q,  fillCnt_d;
    logic [CW-1:0]   discard_q,  discard_d;
    logic [DEPTH-1:0] filled_q,  filled_d;
    logic            protoErr_q, protoErr_d;

    logic [XLEN-1:0] pcMem_q   [DEPTH];
    logic [XLEN-1:0] instMem_q [DEPTH];

    logic [CW:0]     allocSum;
    logic [CW:0]     flushSum;
    logic [CW-1:0]   unfilled;
    logic            headValid;
    logic            issue;
    logic            pop;
    logic            respDrop;
    logic            fill;
    logic            protoHit;

    // Handshake decisions, all taken from registered state plus this cycle's inputs
    always_comb begin
        allocSum  = {1'b0, alloc_q} + {1'b0, discard_q};
        unfilled  = alloc_q - fillCnt_q;
        headValid = filled_q[rdPtr_q];
        issue     = rst & ~i_flush & (allocSum < (CW+1)'(DEPTH));
        pop       = headValid & i_ready & ~i_flush;
        respDrop  = i_IM_valid & ~i_flush & (discard_q != '0);
        fill      = i_IM_valid & ~i_flush & (discard_q == '0) & (unfilled != '0);
        protoHit  = i_IM_valid & (discard_q == '0) & (unfilled == '0);
        flushSum  = {1'b0, discard_q} + {1'b0, unfilled};
        if (i_IM_valid && flushSum != '0) begin
            flushSum = flushSum - (CW+1)'(1);
        end
    end

    // Next-state for pointers, counters and fill flags; flush overrides everything
    always_comb begin
        fetchPc_d  = fetchPc_q;
        allocPtr_d = allocPtr_q;
        fillPtr_d  = fillPtr_q;
        rdPtr_d    = rdPtr_q;
        alloc_d    = alloc_q;
        fillCnt_d  = fillCnt_q;
        discard_d  = discard_q;
        filled_d   = filled_q;
        protoErr_d = protoErr_q | protoHit;
        if (i_flush) begin
            fetchPc_d  = i_branch_addr;
            allocPtr_d = '0;
            fillPtr_d  = '0;
            rdPtr_d    = '0;
            alloc_d    = '0;
            fillCnt_d  = '0;
            filled_d   = '0;
            discard_d  = flushSum[CW-1:0];
        end else begin
            if (issue) begin
                fetchPc_d            = fetchPc_q + PC_STEP;
                allocPtr_d           = allocPtr_q + PW'(1);
                filled_d[allocPtr_q] = 1'b0;
            end
            if (respDrop) begin
                discard_d = discard_q - CW'(1);
            end
            if (fill) begin
                filled_d[fillPtr_q] = 1'b1;
                fillPtr_d           = fillPtr_q + PW'(1);
            end
            if (pop) begin
                filled_d[rdPtr_q] = 1'b0;
                rdPtr_d           = rdPtr_q + PW'(1);
            end
            alloc_d   = alloc_q + CW'(issue) - CW'(pop);
            fillCnt_d = fillCnt_q + CW'(fill) - CW'(pop);
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc_q  <= RESET_PC;
            allocPtr_q <= '0;
            fillPtr_q  <= '0;
            rdPtr_q    <= '0;
            alloc_q    <= '0;
            fillCnt_q  <= '0;
            discard_q  <= '0;
            filled_q   <= '0;
            protoErr_q <= 1'b0;
        end else begin
            fetchPc_q  <= fetchPc_d;
            allocPtr_q <= allocPtr_d;
            fillPtr_q  <= fillPtr_d;
            rdPtr_q    <= rdPtr_d;
            alloc_q    <= alloc_d;
            fillCnt_q  <= fillCnt_d;
            discard_q  <= discard_d;
            filled_q   <= filled_d;
            protoErr_q <= protoErr_d;
        end
    end

    // Entry storage: pc captured at issue, instruction captured at fill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pcMem_q[i]   <= '0;
                instMem_q[i] <= '0;
            end
        end else begin
            if (issue) begin
                pcMem_q[allocPtr_q] <= fetchPc_q;
            end
            if (fill) begin
                instMem_q[fillPtr_q] <= i_IM_inst;
            end
        end
    end

    assign o_IM_req    = issue;
    assign o_IM_addr   = fetchPc_q;
    assign o_valid     = headValid;
    assign o_pc        = pcMem_q[rdPtr_q];
    assign o_inst      = instMem_q[rdPtr_q];
    assign o_count     = alloc_q;
    assign o_proto_err = protoErr_q;

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Directed bench for ifu_prefetch_queue (DEPTH=4): fetch/fill/pop timing,
// backpressure, flush with stale responses, and the protocol-error flag.
module tb_ifu_prefetch_queue;

    logic        clk;
    logic        rst;
    logic        o_IM_req;
    logic [31:0] o_IM_addr;
    logic        i_IM_valid;
    logic [31:0] i_IM_inst;
    logic        i_flush;
    logic [31:0] i_branch_addr;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        i_ready;
    logic [2:0]  o_count;
    logic        o_proto_err;

    int total = 0;
    int bad   = 0;

    ifu_prefetch_queue #(
        .XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'h4)
    ) dut (
        .clk(clk), .rst(rst),
        .o_IM_req(o_IM_req), .o_IM_addr(o_IM_addr),
        .i_IM_valid(i_IM_valid), .i_IM_inst(i_IM_inst),
        .i_flush(i_flush), .i_branch_addr(i_branch_addr),
        .o_valid(o_valid), .o_pc(o_pc), .o_inst(o_inst),
        .i_ready(i_ready), .o_count(o_count), .o_proto_err(o_proto_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instOf(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One cycle: drive inputs just after the falling edge, settle, then sample
    task automatic applyStimulus(input logic flush, input logic [31:0] target,
                                 input logic rvalid, input logic [31:0] rinst,
                                 input logic ready);
        @(negedge clk);
        rst           = 1'b1;
        i_flush       = flush;
        i_branch_addr = target;
        i_IM_valid    = rvalid;
        i_IM_inst     = rinst;
        i_ready       = ready;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst        = 1'b0;
        i_flush    = 1'b0;
        i_IM_valid = 1'b0;
        i_IM_inst  = '0;
        i_ready    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_req",   32'(o_IM_req),    32'd0);
        checkOutput("rst_valid", 32'(o_valid),     32'd0);
        checkOutput("rst_count", 32'(o_count),     32'd0);
        checkOutput("rst_pc",    o_pc,             32'd0);
        checkOutput("rst_inst",  o_inst,           32'd0);
        checkOutput("rst_perr",  32'(o_proto_err), 32'd0);
    endtask

    initial begin
        rst = 1'b0; i_flush = 1'b0; i_branch_addr = '0;
        i_IM_valid = 1'b0; i_IM_inst = '0; i_ready = 1'b0;

        // Fill the queue with no responses: four issues then stall
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            checkOutput("t1_req",  32'(o_IM_req), 32'd1);
            checkOutput("t1_addr", o_IM_addr,     32'(4*k));
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("t1_full_req", 32'(o_IM_req), 32'd0);
        checkOutput("t1_count",    32'(o_count),  32'd4);
        checkOutput("t1_valid",    32'(o_valid),  32'd0);

        // Latency-1 memory with decode always ready: one instruction per cycle
        doReset();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 32'h0, k >= 2, instOf(32'(4*(k-2))), 1'b1);
            checkOutput("t2_req",   32'(o_IM_req), 32'd1);
            checkOutput("t2_addr",  o_IM_addr,     32'(4*(k-1)));
            checkOutput("t2_count", 32'(o_count),  (k == 1) ? 32'd0 : (k == 2) ? 32'd1 : 32'd2);
            checkOutput("t2_valid", 32'(o_valid),  (k >= 3) ? 32'd1 : 32'd0);
            if (k >= 3) begin
                checkOutput("t2_pc",   o_pc,   32'(4*(k-3)));
                checkOutput("t2_inst", o_inst, instOf(32'(4*(k-3))));
            end
        end
        checkOutput("t2_perr", 32'(o_proto_err), 32'd0);

        // Backpressure: queue fills, head holds, then drains in order
        doReset();
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b0, 32'h0, k >= 2, instOf(32'(4*(k-2))), 1'b0);
            if (k <= 4) begin
                checkOutput("t3_req",  32'(o_IM_req), 32'd1);
                checkOutput("t3_addr", o_IM_addr,     32'(4*(k-1)));
            end
        end
        checkOutput("t3_full_req", 32'(o_IM_req), 32'd0);
        checkOutput("t3_hold_val", 32'(o_valid),  32'd1);
        checkOutput("t3_hold_pc",  o_pc,          32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("t3_stall_req", 32'(o_IM_req), 32'd0);
        checkOutput("t3_stall_pc",  o_pc,          32'h0);
        checkOutput("t3_stall_ins", o_inst,        instOf(32'h0));
        checkOutput("t3_stall_cnt", 32'(o_count),  32'd4);
        for (int k = 7; k <= 10; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            checkOutput("t3_pop_val",  32'(o_valid), 32'd1);
            checkOutput("t3_pop_pc",   o_pc,         32'(4*(k-7)));
            checkOutput("t3_pop_inst", o_inst,       instOf(32'(4*(k-7))));
            checkOutput("t3_pop_cnt",  32'(o_count), (k == 7) ? 32'd4 : 32'd3);
            checkOutput("t3_pop_req",  32'(o_IM_req), (k == 7) ? 32'd0 : 32'd1);
            if (k >= 8) begin
                checkOutput("t3_resume", o_IM_addr, 32'(32'h10 + 4*(k-8)));
            end
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("t3_empty_val", 32'(o_valid), 32'd0);
        checkOutput("t3_empty_cnt", 32'(o_count), 32'd3);

        // Flush with three fetches in flight; stale responses must vanish
        doReset();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            checkOutput("t4_addr", o_IM_addr, 32'(4*(k-1)));
        end
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        checkOutput("t4_flush_req", 32'(o_IM_req), 32'd0);
        checkOutput("t4_flush_cnt", 32'(o_count),  32'd3);
        for (int k = 5; k <= 7; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_0000 | 32'(4*(k-5)), 1'b1);
            checkOutput("t4_req",   32'(o_IM_req), 32'd1);
            checkOutput("t4_addr2", o_IM_addr,     32'(32'h100 + 4*(k-5)));
            checkOutput("t4_stale", 32'(o_valid),  32'd0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, instOf(32'h100), 1'b1);
        checkOutput("t4_addr3", o_IM_addr,    32'h10C);
        checkOutput("t4_wait",  32'(o_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, instOf(32'h104), 1'b1);
        checkOutput("t4_valid", 32'(o_valid),  32'd1);
        checkOutput("t4_pc",    o_pc,          32'h100);
        checkOutput("t4_inst",  o_inst,        instOf(32'h100));
        checkOutput("t4_fullq", 32'(o_IM_req), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("t4_pc2",   o_pc,          32'h104);
        checkOutput("t4_inst2", o_inst,        instOf(32'h104));
        checkOutput("t4_addr4", o_IM_addr,     32'h110);

        // Flush coinciding with a response and a would-be pop
        doReset();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 32'h0, k == 2, instOf(32'h0), 1'b0);
            checkOutput("t5_addr", o_IM_addr, 32'(4*(k-1)));
        end
        applyStimulus(1'b1, 32'h200, 1'b1, instOf(32'h4), 1'b1);
        checkOutput("t5_flush_req", 32'(o_IM_req), 32'd0);
        checkOutput("t5_flush_val", 32'(o_valid),  32'd1);
        checkOutput("t5_flush_pc",  o_pc,          32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_0008, 1'b1);
        checkOutput("t5_cnt0",  32'(o_count),  32'd0);
        checkOutput("t5_val0",  32'(o_valid),  32'd0);
        checkOutput("t5_req",   32'(o_IM_req), 32'd1);
        checkOutput("t5_tgt",   o_IM_addr,     32'h200);
        applyStimulus(1'b0, 32'h0, 1'b1, instOf(32'h200), 1'b1);
        checkOutput("t5_val1",  32'(o_valid),  32'd0);
        checkOutput("t5_addr2", o_IM_addr,     32'h204);
        checkOutput("t5_cnt1",  32'(o_count),  32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("t5_val2",  32'(o_valid),  32'd1);
        checkOutput("t5_pc",    o_pc,          32'h200);
        checkOutput("t5_inst",  o_inst,        instOf(32'h200));
        checkOutput("t5_cnt2",  32'(o_count),  32'd2);

        // Unsolicited response sets the sticky protocol error only
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        checkOutput("t6_perr0", 32'(o_proto_err), 32'd0);
        checkOutput("t6_req",   32'(o_IM_req),    32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("t6_perr1", 32'(o_proto_err), 32'd1);
        checkOutput("t6_cnt",   32'(o_count),     32'd1);
        checkOutput("t6_val",   32'(o_valid),     32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, instOf(32'h0), 1'b0);
        checkOutput("t6_val2",  32'(o_valid),     32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("t6_val3",  32'(o_valid),     32'd1);
        checkOutput("t6_pc",    o_pc,             32'h0);
        checkOutput("t6_inst",  o_inst,           instOf(32'h0));
        checkOutput("t6_sticky", 32'(o_proto_err), 32'd1);
        doReset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
